alsaqr_valrdy_to_credit: RTL and testbench

ALSAQR_VALRDY_TO_CREDIT -- requirements
Module: alsaqr_valrdy_to_credit

---
 rtl/alsaqr_noc_pkg.sv | 12 +
 rtl/alsaqr_skid_buf2.sv | 66 ++++++
 rtl/alsaqr_valrdy_to_credit.sv | 86 ++++++++
 tb/tb_alsaqr_valrdy_to_credit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alsaqr_noc_pkg.sv
// Shared NoC link parameters: both ends of a credit link must agree on flit width and buffer depth.
package alsaqr_noc_pkg;

  localparam int unsigned NOC_DATA_WIDTH = 64;
  localparam int unsigned NOC_CREDITS    = 16;

  // Counter must hold every value 0..credits inclusive.
  function automatic int unsigned credit_cnt_width(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/alsaqr_skid_buf2.sv
// Two-entry in-order val/rdy buffer with a registered ready; head entry is presented combinationally.
module alsaqr_skid_buf2
  import alsaqr_noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = NOC_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] slot_q [2];
  logic [DATA_WIDTH-1:0] slot_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  in_ready_q, in_ready_d;
  logic                  accept;
  logic                  pop;

  assign accept    = in_valid & in_ready_q;
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = slot_q[rd_ptr_q];
  assign in_ready  = in_ready_q;

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      slot_d[wr_ptr_q] = in_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d      = occ_q + {1'b0, accept} - {1'b0, pop};
    // Ready reflects the occupancy we will have next cycle, so it can be a plain flop.
    in_ready_d = (occ_d < 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= '0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/alsaqr_valrdy_to_credit.sv
// Val/rdy producer to credit-based link bridge: skid buffer, credit counter and registered link output.
module alsaqr_valrdy_to_credit
  import alsaqr_noc_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = NOC_DATA_WIDTH,
  parameter  int unsigned CREDITS    = NOC_CREDITS,
  localparam int unsigned CNT_W      = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  yummy_out,
  output logic [CNT_W-1:0]      credit_cnt,
  output logic                  credit_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_valid;
  logic                  buf_ready;
  logic                  send;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  alsaqr_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (data_in),
    .in_valid  (valid_in),
    .in_ready  (ready_in),
    .out_data  (buf_data),
    .out_valid (buf_valid),
    .out_ready (buf_ready)
  );

  // Only the registered count gates a send, so a same-cycle yummy cannot unblock it.
  assign buf_ready = (cnt_q != '0);
  assign send      = buf_valid & buf_ready;

  always_comb begin
    cnt_d       = cnt_q;
    err_d       = err_q;
    valid_out_d = send;
    data_out_d  = send ? buf_data : data_out_q;
    if (send && !yummy_out) begin
      cnt_d = cnt_q - CNT_ONE;
    end else if (!send && yummy_out) begin
      if (cnt_q == CNT_MAX) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= CNT_MAX;
      err_q       <= 1'b0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign credit_cnt = cnt_q;
  assign credit_err = err_q;
  assign valid_out  = valid_out_q;
  assign data_out   = data_out_q;

endmodule

// File: tb/tb_alsaqr_valrdy_to_credit.sv
// Scoreboard bench: accepted flits queue up in order, a monitor pops them on each link pulse and
// tracks credits as "initial credits minus sends plus returns, saturating at the buffer depth".
module tb_alsaqr_valrdy_to_credit;

  localparam int DW  = 64;
  localparam int CRD = 16;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          yummy_out;
  logic [4:0]    credit_cnt;
  logic          credit_err;

  alsaqr_valrdy_to_credit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .yummy_out  (yummy_out),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  logic [DW-1:0] sb_q[$];
  int            m_cnt     = CRD;
  bit            m_err     = 1'b0;
  logic [DW-1:0] last_sent = '0;
  int            sent_cnt  = 0;
  bit            mon_acc, mon_y, mon_must;
  logic [DW-1:0] mon_data, mon_exp;

  always @(posedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_cnt     = CRD;
      m_err     = 1'b0;
      last_sent = '0;
      sent_cnt  = 0;
    end else begin
      mon_acc  = valid_in && ready_in;
      mon_data = data_in;
      mon_y    = yummy_out;
      // A flit already held before this edge must go out now if any credit is available.
      mon_must = (sb_q.size() > 0) && (m_cnt > 0);
      #1;
      chk("valid_out", valid_out, mon_must);
      if (valid_out) sent_cnt++;
      if (mon_must) begin
        mon_exp = sb_q.pop_front();
        if (valid_out) chk("data_out", data_out, mon_exp);
        last_sent = mon_exp;
      end else begin
        chk("data_hold", data_out, last_sent);
      end
      if (mon_acc) sb_q.push_back(mon_data);
      if (mon_must && !mon_y) m_cnt--;
      else if (!mon_must && mon_y) begin
        if (m_cnt == CRD) m_err = 1'b1;
        else m_cnt++;
      end
      chk("credit_cnt", credit_cnt, m_cnt);
      chk("credit_err", credit_err, m_err);
      chk("ready_in", ready_in, sb_q.size() < 2);
      $display("cyc t=%0t acc=%0d y=%0d send=%0d data_out=%0h cnt=%0d err=%0d rdy=%0d",
               $time, mon_acc, mon_y, valid_out, data_out, credit_cnt, credit_err, ready_in);
    end
  end

  // ---------------- stimulus ----------------
  bit main_acc;
  int idx;
  int nflits;

  task automatic step();
    @(posedge clk);
    main_acc = valid_in && ready_in;
    #2;
  endtask

  task automatic step_stream();
    step();
    if (main_acc) begin
      idx++;
      data_in = DW'(idx);
      if (idx >= nflits) valid_in = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    yummy_out = 1'b0;
    data_in   = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic start_stream(input int n);
    idx      = 0;
    nflits   = n;
    data_in  = '0;
    valid_in = 1'b1;
  endtask

  int  sent_mark;
  logic [4:0] cnt_mark;

  initial begin
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    yummy_out = 1'b0;
    data_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_data_out", data_out, '0);
    chk("rst_credit_cnt", credit_cnt, CRD);
    chk("rst_credit_err", credit_err, 1'b0);
    chk("rst_ready_in", ready_in, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", ready_in, 1'b1);
    #1;

    // Single flit 0xA5
    valid_in = 1'b1;
    data_in  = 64'hA5;
    step();
    chk("a5_accepted", main_acc, 1'b1);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("a5_valid_out", valid_out, 1'b1);
    chk("a5_data_out", data_out, 64'hA5);
    chk("a5_credit_cnt", credit_cnt, 15);
    #1;
    repeat (3) step();

    // Stream 20 flits with no credit return
    do_reset();
    start_stream(20);
    repeat (40) step_stream();
    chk("s20_sent", sent_cnt, 16);
    chk("s20_credit_cnt", credit_cnt, 0);
    chk("s20_ready_low", ready_in, 1'b0);
    chk("s20_accepted", idx, 18);

    // Return four credits, one at a time
    for (int k = 0; k < 4; k++) begin
      yummy_out = 1'b1;
      step_stream();
      yummy_out = 1'b0;
      repeat (4) step_stream();
    end
    chk("y4_sent", sent_cnt, 20);
    chk("y4_credit_cnt", credit_cnt, 0);
    chk("y4_accepted", idx, 20);

    // Sustained stream with a credit returned every cycle
    do_reset();
    start_stream(1000);
    for (int c = 0; c < 40; c++) begin
      if (c == 3) yummy_out = 1'b1;
      if (c == 10) begin
        sent_mark = sent_cnt;
        cnt_mark  = credit_cnt;
      end
      step_stream();
    end
    chk("steady_rate", sent_cnt - sent_mark, 30);
    chk("steady_cnt", credit_cnt, cnt_mark);
    yummy_out = 1'b0;
    valid_in  = 1'b0;

    // Over-return while idle at full credits
    do_reset();
    repeat (3) step();
    yummy_out = 1'b1;
    step();
    yummy_out = 1'b0;
    step();
    chk("ovf_err_set", credit_err, 1'b1);
    chk("ovf_cnt_sat", credit_cnt, CRD);
    repeat (5) step();
    chk("ovf_err_sticky", credit_err, 1'b1);

    // Asynchronous reset in the middle of traffic
    do_reset();
    start_stream(1000);
    repeat (7) step_stream();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_out", valid_out, 1'b0);
    chk("mid_rst_credit_cnt", credit_cnt, CRD);
    chk("mid_rst_ready_in", ready_in, 1'b0);
    chk("mid_rst_data_out", data_out, '0);
    chk("mid_rst_credit_err", credit_err, 1'b0);
    #1;
    do_reset();
    repeat (6) step();
    chk("no_stale_flit", sent_cnt, 0);

    // Randomized traffic with a mid-run reset
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      valid_in  = ($urandom_range(0, 9) < 7);
      data_in   = {$urandom, $urandom};
      yummy_out = ($urandom_range(0, 9) < 3);
      step();
    end
    valid_in  = 1'b0;
    yummy_out = 1'b0;
    repeat (25) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
